// File: rtl/collatz_range_par_if.sv
// Host-side bundle for collatz_range_par: run control, result read port and status.
// COLLATZ_MAX_TRACK_EN adds the max_count/max_index result ports.
interface collatz_range_par_if #(
  parameter int N_BITS        = 32,
  parameter int COUNT_BITS    = 16,
  parameter int RAM_ADDR_BITS = 4
);
  logic                     go;
  logic [N_BITS-1:0]        start;
  logic [RAM_ADDR_BITS-1:0] rd_addr;
  logic                     busy;
  logic                     done;
  logic [COUNT_BITS-1:0]    count;
  logic                     overflow;
`ifdef COLLATZ_MAX_TRACK_EN
  logic [COUNT_BITS-1:0]    max_count;
  logic [RAM_ADDR_BITS-1:0] max_index;

  modport master (
    output go, start, rd_addr,
    input  busy, done, count, overflow, max_count, max_index
  );
  modport slave (
    input  go, start, rd_addr,
    output busy, done, count, overflow, max_count, max_index
  );
`else
  modport master (
    output go, start, rd_addr,
    input  busy, done, count, overflow
  );
  modport slave (
    input  go, start, rd_addr,
    output busy, done, count, overflow
  );
`endif
endinterface

// File: rtl/collatz_range_par.sv
// Parallel Collatz range scanner: N_ENGINES iterators fill a RAM_WORDS result memory.
// Optional feature macro: COLLATZ_MAX_TRACK_EN (largest count and its lowest index per run).
module collatz_range_par #(
  parameter int N_BITS        = 32,
  parameter int COUNT_BITS    = 16,
  parameter int RAM_WORDS     = 16,
  parameter int RAM_ADDR_BITS = 4,
  parameter int N_ENGINES     = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  collatz_range_par_if.slave  bus
);
  localparam int IDX_W = RAM_ADDR_BITS + 1;
  localparam int ENG_W = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
  localparam logic [IDX_W-1:0]      WORDS_C = IDX_W'(RAM_WORDS);
  localparam logic [COUNT_BITS-1:0] CNT_MAX = {COUNT_BITS{1'b1}};

  typedef enum logic [1:0] {ENG_IDLE, ENG_RUN, ENG_HOLD} eng_state_e;

  eng_state_e               state_q [N_ENGINES];
  eng_state_e               state_d [N_ENGINES];
  logic [N_BITS-1:0]        n_q     [N_ENGINES];
  logic [N_BITS-1:0]        n_d     [N_ENGINES];
  logic [RAM_ADDR_BITS-1:0] tag_q   [N_ENGINES];
  logic [RAM_ADDR_BITS-1:0] tag_d   [N_ENGINES];
  logic [COUNT_BITS-1:0]    cnt_q   [N_ENGINES];
  logic [COUNT_BITS-1:0]    cnt_d   [N_ENGINES];

  logic [N_BITS-1:0]        base_q, base_d;
  logic [IDX_W-1:0]         next_idx_q, next_idx_d;
  logic [IDX_W-1:0]         completed_q, completed_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     ovf_q, ovf_d;
  logic [COUNT_BITS-1:0]    count_q, count_d;

  logic                     disp_valid, disp_en, grant_valid, step_ovf, go_accept;
  logic [ENG_W-1:0]         disp_sel, grant_sel;
  logic [RAM_ADDR_BITS-1:0] wr_addr;
  logic [COUNT_BITS-1:0]    wr_data;

  logic [COUNT_BITS-1:0]    mem [RAM_WORDS];

  assign go_accept = bus.go && !busy_q;

  // Lowest-numbered engine wins both the dispatch slot and the write port.
  always_comb begin
    disp_valid  = 1'b0;
    disp_sel    = '0;
    grant_valid = 1'b0;
    grant_sel   = '0;
    for (int e = N_ENGINES - 1; e >= 0; e--) begin
      if (state_q[e] == ENG_IDLE) begin
        disp_valid = 1'b1;
        disp_sel   = ENG_W'(e);
      end
      if (state_q[e] == ENG_HOLD) begin
        grant_valid = 1'b1;
        grant_sel   = ENG_W'(e);
      end
    end
    disp_en = disp_valid && busy_q && (next_idx_q < WORDS_C);
  end

  assign wr_addr = tag_q[grant_sel];
  assign wr_data = cnt_q[grant_sel];

  // Engine next-state: load, iterate, then wait in HOLD until the write port is granted.
  always_comb begin
    logic [N_BITS+1:0] step3;
    step3    = '0;
    step_ovf = 1'b0;
    for (int e = 0; e < N_ENGINES; e++) begin
      state_d[e] = state_q[e];
      n_d[e]     = n_q[e];
      tag_d[e]   = tag_q[e];
      cnt_d[e]   = cnt_q[e];
      case (state_q[e])
        ENG_IDLE: begin
          if (disp_en && disp_sel == ENG_W'(e)) begin
            state_d[e] = ENG_RUN;
            n_d[e]     = base_q + N_BITS'(next_idx_q[RAM_ADDR_BITS-1:0]);
            tag_d[e]   = next_idx_q[RAM_ADDR_BITS-1:0];
            cnt_d[e]   = COUNT_BITS'(1);
          end
        end
        ENG_RUN: begin
          if (n_q[e] == N_BITS'(1)) begin
            state_d[e] = ENG_HOLD;
          end else if (n_q[e] == '0) begin
            cnt_d[e]   = '0;
            state_d[e] = ENG_HOLD;
          end else begin
            if (n_q[e][0]) begin
              step3  = ({2'b00, n_q[e]} << 1) + {2'b00, n_q[e]} + (N_BITS+2)'(1);
              n_d[e] = step3[N_BITS-1:0];
              if (|step3[N_BITS+1:N_BITS]) begin
                step_ovf = 1'b1;
              end
            end else begin
              n_d[e] = n_q[e] >> 1;
            end
            if (cnt_q[e] != CNT_MAX) begin
              cnt_d[e] = cnt_q[e] + COUNT_BITS'(1);
            end
          end
        end
        ENG_HOLD: begin
          if (grant_valid && grant_sel == ENG_W'(e)) begin
            state_d[e] = ENG_IDLE;
          end
        end
        default: state_d[e] = ENG_IDLE;
      endcase
    end
  end

  always_comb begin
    base_d      = base_q;
    next_idx_d  = next_idx_q;
    completed_d = completed_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q | step_ovf;
    if (go_accept) begin
      base_d      = bus.start;
      next_idx_d  = '0;
      completed_d = '0;
      busy_d      = 1'b1;
      ovf_d       = 1'b0;
    end else if (busy_q) begin
      if (disp_en) begin
        next_idx_d = next_idx_q + IDX_W'(1);
      end
      if (grant_valid) begin
        completed_d = completed_q + IDX_W'(1);
      end
      if (completed_q == WORDS_C) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = mem[bus.rd_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < N_ENGINES; e++) begin
        state_q[e] <= ENG_IDLE;
        n_q[e]     <= '0;
        tag_q[e]   <= '0;
        cnt_q[e]   <= '0;
      end
      base_q      <= '0;
      next_idx_q  <= '0;
      completed_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      for (int e = 0; e < N_ENGINES; e++) begin
        state_q[e] <= state_d[e];
        n_q[e]     <= n_d[e];
        tag_q[e]   <= tag_d[e];
        cnt_q[e]   <= cnt_d[e];
      end
      base_q      <= base_d;
      next_idx_q  <= next_idx_d;
      completed_q <= completed_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
    end
  end

  // Result memory keeps its contents across reset; a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (grant_valid) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

`ifdef COLLATZ_MAX_TRACK_EN
  logic [COUNT_BITS-1:0]    max_count_q, max_count_d;
  logic [RAM_ADDR_BITS-1:0] max_index_q, max_index_d;

  // Equal counts resolve to the lower index, so the result is independent of write order.
  always_comb begin
    max_count_d = max_count_q;
    max_index_d = max_index_q;
    if (go_accept) begin
      max_count_d = '0;
      max_index_d = '0;
    end else if (grant_valid) begin
      if ((wr_data > max_count_q) ||
          (wr_data == max_count_q && wr_addr < max_index_q)) begin
        max_count_d = wr_data;
        max_index_d = wr_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_count_q <= '0;
      max_index_q <= '0;
    end else begin
      max_count_q <= max_count_d;
      max_index_q <= max_index_d;
    end
  end

  assign bus.max_count = max_count_q;
  assign bus.max_index = max_index_q;
`endif
endmodule

// File: tb/tb_collatz_range_par.sv
// Bench for collatz_range_par: two 32-bit instances (2 and 4 engines) in lockstep plus a
// narrow 8-bit/4-bit-count instance for saturation, overflow, go-while-busy and latency.
module tb_collatz_range_par;
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  collatz_range_par_if #(.N_BITS(32), .COUNT_BITS(16), .RAM_ADDR_BITS(4)) if_a ();
  collatz_range_par_if #(.N_BITS(32), .COUNT_BITS(16), .RAM_ADDR_BITS(4)) if_b ();
  collatz_range_par_if #(.N_BITS(8),  .COUNT_BITS(4),  .RAM_ADDR_BITS(1)) if_c ();

  assign if_b.go      = if_a.go;
  assign if_b.start   = if_a.start;
  assign if_b.rd_addr = if_a.rd_addr;

  collatz_range_par #(.N_BITS(32), .COUNT_BITS(16), .RAM_WORDS(16), .RAM_ADDR_BITS(4),
                      .N_ENGINES(2)) u_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
  collatz_range_par #(.N_BITS(32), .COUNT_BITS(16), .RAM_WORDS(16), .RAM_ADDR_BITS(4),
                      .N_ENGINES(4)) u_b (.clk(clk), .reset_n(reset_n), .bus(if_b));
  collatz_range_par #(.N_BITS(8), .COUNT_BITS(4), .RAM_WORDS(2), .RAM_ADDR_BITS(1),
                      .N_ENGINES(1)) u_c (.clk(clk), .reset_n(reset_n), .bus(if_c));

  typedef struct {
    logic [31:0] start;
    int          exp [16];
    bit          ovf;
  } vec_t;

  vec_t vecs [5];
  int   exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: number of terms to reach 1, with N-bit truncation and count saturation.
  function automatic void ref_len(input longint unsigned s, input int nbits, input int cbits,
                                  output int cnt, output bit ovf);
    longint unsigned mask;
    longint unsigned n;
    longint unsigned m;
    int              cmax;
    mask = (64'd1 << nbits) - 1;
    n    = s & mask;
    cmax = (1 << cbits) - 1;
    ovf  = 1'b0;
    cnt  = (n == 0) ? 0 : 1;
    for (int i = 0; i < 100000 && n > 1; i++) begin
      if (n[0]) begin
        m = 3 * n + 1;
        if (m > mask) ovf = 1'b1;
        n = m & mask;
      end else begin
        n = n >> 1;
      end
      if (cnt < cmax) cnt++;
    end
  endfunction

`ifdef COLLATZ_MAX_TRACK_EN
  function automatic void exp_max(input int vi, output int mc, output int mi);
    mc = 0;
    mi = 0;
    for (int i = 0; i < 16; i++) begin
      if (vecs[vi].exp[i] > mc) begin
        mc = vecs[vi].exp[i];
        mi = i;
      end
    end
  endfunction
`endif

  task automatic run_ab(input logic [31:0] s);
    int da;
    int db;
    bit ok;
    da = 0;
    db = 0;
    ok = 1'b0;
    @(negedge clk);
    if_a.start = s;
    if_a.go    = 1'b1;
    @(negedge clk);
    if_a.go = 1'b0;
    chk("a_busy_after_go", if_a.busy, 1);
    chk("b_busy_after_go", if_b.busy, 1);
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (if_a.done) da++;
      if (if_b.done) db++;
      if (!if_a.busy && !if_b.busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (if_a.done) da++;
      if (if_b.done) db++;
    end
    chk("ab_run_finished", ok, 1);
    chk("a_done_cycles", da, 1);
    chk("b_done_cycles", db, 1);
  endtask

  // Scoreboard read: expectation pushed with the address, popped when count is valid.
  task automatic read_ab(input int vi);
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        int e;
        e = exp_q.pop_front();
        chk($sformatf("a_mem[%0d] start=%0d", i - 1, vecs[vi].start), if_a.count, e);
        chk($sformatf("b_mem[%0d] start=%0d", i - 1, vecs[vi].start), if_b.count, e);
      end
      if (i < 16) begin
        if_a.rd_addr = 4'(i);
        exp_q.push_back(vecs[vi].exp[i]);
      end
    end
    chk("a_overflow", if_a.overflow, vecs[vi].ovf);
    chk("b_overflow", if_b.overflow, vecs[vi].ovf);
`ifdef COLLATZ_MAX_TRACK_EN
    begin
      int mc;
      int mi;
      exp_max(vi, mc, mi);
      chk("a_max_count", if_a.max_count, mc);
      chk("a_max_index", if_a.max_index, mi);
      chk("b_max_count", if_b.max_count, mc);
      chk("b_max_index", if_b.max_index, mi);
    end
`endif
  endtask

  task automatic run_c(input logic [7:0] s, input int exp_lat, input bit hold_go);
    int lat;
    int dn;
    int first;
    bit ok;
    lat   = 0;
    dn    = 0;
    first = -1;
    ok    = 1'b0;
    @(negedge clk);
    if_c.start = s;
    if_c.go    = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if_c.go = 1'b0;
        chk("c_busy_after_go", if_c.busy, 1);
      end
      if (hold_go && lat == 3) begin
        if_c.go    = 1'b1;
        if_c.start = 8'd27;
      end
      if (hold_go && lat == 6) if_c.go = 1'b0;
      if (if_c.done) begin
        dn++;
        if (first < 0) first = lat;
      end
      if (!if_c.busy && lat > 1) begin
        ok = 1'b1;
        break;
      end
    end
    if_c.go = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (if_c.done) dn++;
    end
    chk("c_run_finished", ok, 1);
    chk("c_done_cycles", dn, 1);
    chk("c_idle_after_run", if_c.busy, 0);
    if (exp_lat > 0) chk("c_done_latency", first, exp_lat);
  endtask

  task automatic read_c(input int e0, input int e1, input bit eovf);
    for (int i = 0; i <= 2; i++) begin
      @(negedge clk);
      if (i > 0) begin
        int e;
        e = exp_q.pop_front();
        chk($sformatf("c_mem[%0d]", i - 1), if_c.count, e);
      end
      if (i < 2) begin
        if_c.rd_addr = 1'(i);
        exp_q.push_back(i == 0 ? e0 : e1);
      end
    end
    chk("c_overflow", if_c.overflow, eovf);
`ifdef COLLATZ_MAX_TRACK_EN
    chk("c_max_count", if_c.max_count, (e1 > e0) ? e1 : e0);
    chk("c_max_index", if_c.max_index, (e1 > e0) ? 1 : 0);
`endif
  endtask

  initial begin
    int  c;
    bit  o;
    bit  found;

    vecs[0].start = 32'd1;
    vecs[0].exp   = '{1, 2, 8, 3, 6, 9, 17, 4, 20, 7, 15, 10, 10, 18, 18, 5};
    vecs[0].ovf   = 1'b0;
    vecs[1].start = 32'd13;
    vecs[2].start = 32'd0;
    vecs[3].start = 32'd27;
    vecs[4].start = 32'd100;
    for (int k = 1; k < 5; k++) begin
      vecs[k].ovf = 1'b0;
      for (int i = 0; i < 16; i++) begin
        ref_len(longint'(vecs[k].start) + longint'(i), 32, 16, c, o);
        vecs[k].exp[i] = c;
        if (o) vecs[k].ovf = 1'b1;
      end
    end

    if_a.go = 1'b0; if_a.start = '0; if_a.rd_addr = '0;
    if_c.go = 1'b0; if_c.start = '0; if_c.rd_addr = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #2;
    chk("rst_a_busy", if_a.busy, 0);
    chk("rst_a_done", if_a.done, 0);
    chk("rst_a_count", if_a.count, 0);
    chk("rst_a_overflow", if_a.overflow, 0);
    chk("rst_c_busy", if_c.busy, 0);
    chk("rst_c_count", if_c.count, 0);
`ifdef COLLATZ_MAX_TRACK_EN
    chk("rst_a_max_count", if_a.max_count, 0);
    chk("rst_a_max_index", if_a.max_index, 0);
`endif
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_ab(vecs[v].start);
      read_ab(v);
    end

    run_c(8'd27, -1, 1'b0);
    read_c(15, 15, 1'b1);
    run_c(8'd0, 8, 1'b1);
    read_c(0, 1, 1'b0);

    // Out-of-order: index 1 (28, 19 terms) lands long before index 0 (27, 112 terms).
    run_ab(32'd1);
    @(negedge clk);
    if_a.start   = 32'd27;
    if_a.go      = 1'b1;
    if_a.rd_addr = 4'd1;
    @(negedge clk);
    if_a.go = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (if_a.count == 16'd19) begin
        found = 1'b1;
        break;
      end
    end
    chk("a_ooo_idx1_written", found, 1);
    if_a.rd_addr = 4'd0;
    @(negedge clk);
    chk("a_ooo_idx0_still_old", if_a.count, 1);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!if_a.busy && !if_b.busy) begin
        found = 1'b1;
        break;
      end
    end
    chk("ab_ooo_run_finished", found, 1);
    read_ab(3);

    // Mid-run reset, asserted between clock edges.
    @(negedge clk);
    if_a.start = 32'd27;
    if_a.go    = 1'b1;
    if_c.start = 8'd27;
    if_c.go    = 1'b1;
    @(negedge clk);
    if_a.go = 1'b0;
    if_c.go = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_a_busy", if_a.busy, 1);
    chk("mid_c_overflow", if_c.overflow, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_a_busy", if_a.busy, 0);
    chk("arst_a_done", if_a.done, 0);
    chk("arst_b_busy", if_b.busy, 0);
    chk("arst_c_busy", if_c.busy, 0);
    chk("arst_c_overflow", if_c.overflow, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_ab(32'd1);
    read_ab(0);
    run_c(8'd0, 8, 1'b0);
    read_c(0, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
